cond_branch_sequencer: RTL and testbench

Multi-cycle conditional-branch sequencer for the LEGv8 control unit. It is the parametrised successor to the single-state CBZ/CBNZ decoder:
- owns its own state register and a start/done handshake with the top-level control FSM;
- adds B.cond handling (evaluated on the N, Z, C, V flags) and illegal-opcode reporting;
- drives the 31-bit control word and the K constant onto the datapath while a branch is in flight.

---
 rtl/cond_branch_sequencer_pkg.sv | 77 +++++++
 rtl/cond_eval.sv | 35 +++
 rtl/cond_branch_sequencer.sv | 120 ++++++++++++
 tb/tb_cond_branch_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_branch_sequencer_pkg.sv
// Shared types and constants for the LEGv8 conditional-branch sequencer.
// Holds the FSM encoding, the control-word layout, opcode patterns and condition codes.
package cond_branch_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StEval   = 2'd1,
        StBranch = 2'd2,
        StFault  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        KindCb      = 2'd0,
        KindBc      = 2'd1,
        KindIllegal = 2'd2
    } kind_e;

    localparam int unsigned PSEL_W = 2;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned FSEL_W = 5;
    localparam int unsigned CW_W   = 31;
    localparam int unsigned IMM_W  = 19;

    // Field order, MSB first: psel[30:29] da[28:24] sa[23:19] sb[18:14] fsel[13:9] then flags.
    typedef struct packed {
        logic [PSEL_W-1:0] psel;
        logic [REG_W-1:0]  da;
        logic [REG_W-1:0]  sa;
        logic [REG_W-1:0]  sb;
        logic [FSEL_W-1:0] fsel;
        logic              regw;
        logic              ramw;
        logic              en_mem;
        logic              en_alu;
        logic              en_b;
        logic              en_pc;
        logic              bsel;
        logic              pcsel;
        logic              sl;
    } ctrl_word_t;

    localparam ctrl_word_t CW_NOP = '0;

    localparam logic [FSEL_W-1:0] FSEL_OR_DEFAULT = 5'b00100;
    localparam logic [REG_W-1:0]  DA_NONE         = 5'b11111;

    localparam logic [5:0] OPC_CB = 6'b011010;
    localparam logic [7:0] OPC_BC = 8'h54;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_HS = 4'h2;
    localparam logic [3:0] COND_LO = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'ha;
    localparam logic [3:0] COND_LT = 4'hb;
    localparam logic [3:0] COND_GT = 4'hc;
    localparam logic [3:0] COND_LE = 4'hd;
    localparam logic [3:0] COND_AL = 4'he;
    localparam logic [3:0] COND_NV = 4'hf;

    function automatic kind_e decode_kind(input logic [31:0] ins, input bit en_bcond);
        if (ins[30:25] == OPC_CB) begin
            return KindCb;
        end
        if (en_bcond && (ins[31:24] == OPC_BC) && !ins[4]) begin
            return KindBc;
        end
        return KindIllegal;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// B.cond evaluator: resolves a 4-bit ARM condition code against the N, Z, C, V flags.
module cond_eval
    import cond_branch_sequencer_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       n,
    input  logic       z,
    input  logic       c,
    input  logic       v,
    output logic       pass
);

    always_comb begin
        pass = 1'b0;
        unique case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_HS: pass = c;
            COND_LO: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !(c && !z);
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = !(!z && (n == v));
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_branch_sequencer.sv
// Multi-cycle CBZ/CBNZ/B.cond sequencer: IDLE -> EVAL -> BRANCH (or FAULT) -> IDLE,
// driving the datapath control word and sign-extended imm19 offset while a branch is in flight.
module cond_branch_sequencer
    import cond_branch_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter logic [4:0]  ZERO_REG     = 5'd31,
    parameter logic [4:0]  FSEL_OR      = FSEL_OR_DEFAULT,
    parameter bit          ENABLE_BCOND = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           instruction,
    input  logic [4:0]            status,
    output logic [CW_W-1:0]       controlWord,
    output logic [DATA_WIDTH-1:0] K,
    output logic                  busy,
    output logic                  done,
    output logic                  taken,
    output logic                  illegal
);

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        taken_q, taken_d;

    logic        flag_v, flag_c, flag_z, flag_n, flag_zi;
    logic        cond_pass;
    logic        k_en;
    kind_e       kind;
    ctrl_word_t  cw;

    assign {flag_v, flag_c, flag_z, flag_n, flag_zi} = status;
    assign kind = decode_kind(instr_q, ENABLE_BCOND);

    cond_eval u_cond_eval (
        .cond (instr_q[3:0]),
        .n    (flag_n),
        .z    (flag_z),
        .c    (flag_c),
        .v    (flag_v),
        .pass (cond_pass)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            instr_q <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            taken_q <= taken_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        taken_d = taken_q;
        cw      = CW_NOP;
        k_en    = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        taken   = 1'b0;
        illegal = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    instr_d = instruction;
                    state_d = StEval;
                end
            end
            StEval: begin
                k_en = 1'b1;
                unique case (kind)
                    KindCb: begin
                        // ALU computes XZR | Rt so ZI reflects Rt == 0 this cycle.
                        cw.da   = DA_NONE;
                        cw.sa   = ZERO_REG;
                        cw.sb   = instr_q[4:0];
                        cw.fsel = FSEL_OR;
                        taken_d = flag_zi ^ instr_q[24];
                        state_d = StBranch;
                    end
                    KindBc: begin
                        taken_d = cond_pass;
                        state_d = StBranch;
                    end
                    default: begin
                        state_d = StFault;
                    end
                endcase
            end
            StBranch: begin
                k_en     = 1'b1;
                cw.psel  = {taken_q, 1'b1};
                cw.pcsel = taken_q;
                done     = 1'b1;
                taken    = taken_q;
                state_d  = StIdle;
            end
            StFault: begin
                done    = 1'b1;
                illegal = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign controlWord = cw;
    assign K = k_en ? {{(DATA_WIDTH - IMM_W){instr_q[23]}}, instr_q[23:5]} : '0;

endmodule

// File: tb/tb_cond_branch_sequencer.sv
// Scoreboard bench for cond_branch_sequencer: two instances (B.cond enabled and disabled)
// driven in lockstep, checked by a negedge monitor against an arithmetic reference model.
module tb_cond_branch_sequencer;

    typedef struct {
        logic [30:0] eval_cw;
        logic [30:0] br_cw;
        logic [63:0] eval_k;
        logic [63:0] br_k;
        logic        tk;
        logic        il;
        int          issue;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] instruction;
    logic [4:0]  status;

    logic [30:0] cw0, cw1;
    logic [63:0] k0, k1;
    logic        busy0, busy1, done0, done1, taken0, taken1, ill0, ill1;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];

    cond_branch_sequencer #(
        .DATA_WIDTH   (64),
        .ENABLE_BCOND (1'b1)
    ) u_dut_en (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .instruction (instruction),
        .status      (status),
        .controlWord (cw0),
        .K           (k0),
        .busy        (busy0),
        .done        (done0),
        .taken       (taken0),
        .illegal     (ill0)
    );

    cond_branch_sequencer #(
        .DATA_WIDTH   (64),
        .ENABLE_BCOND (1'b0)
    ) u_dut_dis (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .instruction (instruction),
        .status      (status),
        .controlWord (cw1),
        .K           (k1),
        .busy        (busy1),
        .done        (done1),
        .taken       (taken1),
        .illegal     (ill1)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Status layout {V, C, Z, N, ZI}.
    function automatic bit cond_model(input logic [3:0] cc, input logic [4:0] st);
        bit n, z, c, v;
        n = st[1];
        z = st[2];
        c = st[3];
        v = st[4];
        case (cc)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return c;
            4'd3:    return !c;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return c && !z;
            4'd9:    return !(c && !z);
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return !(!z && (n == v));
            default: return 1'b1;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [4:0] st, input bit en,
                                   input int issue);
        exp_t   e;
        longint off;
        bit     is_cb, is_bc;
        off = longint'(ins[23:5]);
        if (ins[23]) off = off - 524288;
        is_cb = (ins[30:25] == 6'b011010);
        is_bc = !is_cb && en && (ins[31:24] == 8'h54) && (ins[4] == 1'b0);
        e.issue  = issue;
        e.eval_k = 64'(off);
        e.il     = !(is_cb || is_bc);
        e.tk     = 1'b0;
        e.eval_cw = '0;
        if (is_cb) begin
            e.tk = ins[24] ? !st[0] : st[0];
            e.eval_cw = {2'b00, 5'd31, 5'd31, ins[4:0], 5'b00100, 9'b0};
        end else if (is_bc) begin
            e.tk = cond_model(ins[3:0], st);
        end
        if (e.il) begin
            e.br_cw = '0;
            e.br_k  = '0;
        end else begin
            e.br_cw = {e.tk, 1'b1, 27'b0, e.tk, 1'b0};
            e.br_k  = e.eval_k;
        end
        return e;
    endfunction

    task automatic check_dut(input int d, input logic [30:0] cw, input logic [63:0] k,
                             input logic b, input logic dn, input logic tk, input logic il);
        exp_t  e;
        int    n;
        string p;
        p = $sformatf("dut%0d", d);
        n = (d == 0) ? q0.size() : q1.size();
        if (!b && !dn) begin
            chk({p, " idle cw"}, 64'(cw), 64'd0);
            chk({p, " idle K"}, k, 64'd0);
        end else if (n == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s unexpected activity: got busy=%b done=%b required idle", p, b, dn);
        end else begin
            e = (d == 0) ? q0[0] : q1[0];
            if (dn) begin
                chk({p, " done latency"}, 64'(cyc - e.issue), 64'd2);
                chk({p, " busy at done"}, 64'(b), 64'd1);
                chk({p, " branch cw"}, 64'(cw), 64'(e.br_cw));
                chk({p, " branch K"}, k, e.br_k);
                chk({p, " taken"}, 64'(tk), 64'(e.tk));
                chk({p, " illegal"}, 64'(il), 64'(e.il));
                if (d == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end else begin
                chk({p, " eval cw"}, 64'(cw), 64'(e.eval_cw));
                chk({p, " eval K"}, k, e.eval_k);
                chk({p, " eval illegal"}, 64'(il), 64'd0);
            end
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            check_dut(0, cw0, k0, busy0, done0, taken0, ill0);
            check_dut(1, cw1, k1, busy1, done1, taken1, ill1);
        end
    end

    // Called at #1 after a rising edge with the DUTs idle; returns likewise.
    task automatic issue(input logic [31:0] ins, input logic [4:0] st);
        q0.push_back(model(ins, st, 1'b1, cyc));
        q1.push_back(model(ins, st, 1'b0, cyc));
        instruction = ins;
        status      = st;
        start       = 1'b1;
        @(posedge clock); #1;
        start       = 1'b0;
        instruction = $urandom;
        @(posedge clock); #1;
        status      = 5'($urandom);
        @(posedge clock); #1;
    endtask

    initial begin
        logic [4:0]  pats [4];
        logic [31:0] ins;
        int          t;
        pats[0] = 5'b00000;
        pats[1] = 5'b11110;
        pats[2] = 5'b01010;
        pats[3] = 5'b10100;

        reset = 1'b1;
        start = 1'b0;
        instruction = '0;
        status = '0;
        #1;
        chk("reset cw", 64'(cw0), 64'd0);
        chk("reset K", k0, 64'd0);
        chk("reset busy", 64'(busy0), 64'd0);
        chk("reset done", 64'(done0), 64'd0);
        chk("reset taken", 64'(taken0), 64'd0);
        chk("reset illegal", 64'(ill0), 64'd0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        issue(32'hB4000083, 5'b00001);
        issue(32'hB5000083, 5'b00001);
        issue(32'hB5000083, 5'b00000);
        issue(32'h54FFFFC0, 5'b00100);
        issue(32'h8B020020, 5'b00000);

        for (int c = 0; c < 16; c++) begin
            for (int p = 0; p < 4; p++) begin
                ins = 32'h54000000 | (32'($urandom_range(0, 32'h7FFFF)) << 5) | 32'(c);
                issue(ins, pats[p]);
            end
        end

        // start held high: only accepted from IDLE, so at t and t+3.
        t = cyc;
        instruction = 32'hB4000083;
        status = 5'b00001;
        start = 1'b1;
        q0.push_back(model(32'hB4000083, 5'b00001, 1'b1, t));
        q1.push_back(model(32'hB4000083, 5'b00001, 1'b0, t));
        q0.push_back(model(32'hB4000083, 5'b00001, 1'b1, t + 3));
        q1.push_back(model(32'hB4000083, 5'b00001, 1'b0, t + 3));
        for (int i = 1; i <= 6; i++) begin
            @(posedge clock); #1;
            chk($sformatf("held start busy t+%0d", i), 64'(busy0),
                64'((i == 1) || (i == 2) || (i == 4) || (i == 5)));
            if (i == 6) start = 1'b0;
        end
        @(posedge clock); #1;

        // Reset during EVAL aborts without a done pulse.
        instruction = 32'hB4000083;
        status = 5'b00001;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("pre-reset busy", 64'(busy0), 64'd1);
        reset = 1'b1;
        #1;
        chk("abort cw", 64'(cw0), 64'd0);
        chk("abort K", k0, 64'd0);
        chk("abort busy", 64'(busy0), 64'd0);
        chk("abort done", 64'(done0), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        issue(32'hB4000083, 5'b00001);

        for (int r = 0; r < 300; r++) begin
            ins = $urandom;
            case ($urandom_range(0, 3))
                0: ins[30:25] = 6'b011010;
                1: begin
                    ins[31:24] = 8'h54;
                    ins[4] = ($urandom_range(0, 7) == 0);
                end
                default: ;
            endcase
            issue(ins, 5'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end

        repeat (4) @(posedge clock);
        #1;
        chk("dut0 queue drained", 64'(q0.size()), 64'd0);
        chk("dut1 queue drained", 64'(q1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
